// File: rtl/move_validator.sv
// Chess move-legality checker: captures a move on start, reads the destination
// and any intermediate squares from board memory, then pulses done with a held
// valid verdict. Optional feature macro: MOVE_VALIDATOR_PAWN_DOUBLE_EN.
module move_validator #(
  parameter int BOARD_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            piece,
  input  logic                  current_player,
  input  logic [BOARD_BITS-1:0] from_x,
  input  logic [BOARD_BITS-1:0] from_y,
  input  logic [BOARD_BITS-1:0] to_x,
  input  logic [BOARD_BITS-1:0] to_y,
  output logic [BOARD_BITS-1:0] rd_x,
  output logic [BOARD_BITS-1:0] rd_y,
  input  logic [3:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [2:0]            state_dbg
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse in the
  // DONE state and valid holds its verdict until the next accepted start.
  localparam int CW = BOARD_BITS + 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, DADDR, DDATA, PADDR, PDATA, DONE
  } state_t;

  state_t                state;
  logic [3:0]            piece_q;
  logic                  player_q;
  logic [BOARD_BITS-1:0] fx_q, fy_q, tx_q, ty_q;
  logic [BOARD_BITS-1:0] cx_q, cy_q, sx_q, sy_q;
  logic                  walk_q, pawn_straight_q, pawn_diag_q;

  logic [CW-1:0]         dx, dy, adx, ady, fwd, fwd2;
  logic [3:0]            kind;
  logic                  piece_ok, same_sq, geom_ok;
  logic                  rook_ok, bishop_ok, knight_ok, king_ok;
  logic                  pawn_single, pawn_diag, pawn_double;
  logic                  walk_needed;
  logic [BOARD_BITS-1:0] start_rank, sx_c, sy_c, nx, ny;
  logic                  rd_owner, dest_own, dest_opp, next_is_to;

  assign state_dbg = state;

  always_comb begin
    // Differences are kept in CW-bit two's complement so sign and magnitude
    // both fit for any pair of on-board coordinates.
    dx   = {1'b0, tx_q} - {1'b0, fx_q};
    dy   = {1'b0, ty_q} - {1'b0, fy_q};
    adx  = dx[CW-1] ? -dx : dx;
    ady  = dy[CW-1] ? -dy : dy;
    kind = (piece_q > 4'd6) ? piece_q - 4'd6 : piece_q;

    piece_ok = (piece_q != 4'd0) && (piece_q <= 4'd12) &&
               ((piece_q > 4'd6) == player_q);
    same_sq  = (fx_q == tx_q) && (fy_q == ty_q);

    rook_ok   = (dx == '0) ^ (dy == '0);
    bishop_ok = (adx == ady);
    knight_ok = ((adx == CW'(1)) && (ady == CW'(2))) ||
                ((adx == CW'(2)) && (ady == CW'(1)));
    king_ok   = (adx <= CW'(1)) && (ady <= CW'(1));

    fwd        = player_q ? {CW{1'b1}} : CW'(1);
    fwd2       = fwd + fwd;
    start_rank = player_q ? BOARD_BITS'((1 << BOARD_BITS) - 2) : BOARD_BITS'(1);

    pawn_single = (dx == fwd) && (dy == '0);
    pawn_diag   = (dx == fwd) && (ady == CW'(1));
`ifdef MOVE_VALIDATOR_PAWN_DOUBLE_EN
    pawn_double = (dx == fwd2) && (dy == '0) && (fx_q == start_rank);
`else
    pawn_double = 1'b0;
`endif

    case (kind)
      4'd1:    geom_ok = pawn_single || pawn_diag || pawn_double;
      4'd2:    geom_ok = rook_ok;
      4'd3:    geom_ok = knight_ok;
      4'd4:    geom_ok = bishop_ok;
      4'd5:    geom_ok = rook_ok || bishop_ok;
      4'd6:    geom_ok = king_ok;
      default: geom_ok = 1'b0;
    endcase

    walk_needed = (kind == 4'd2) || (kind == 4'd4) || (kind == 4'd5) ||
                  ((kind == 4'd1) && pawn_double);

    sx_c = (dx == '0) ? '0 : (dx[CW-1] ? '1 : BOARD_BITS'(1));
    sy_c = (dy == '0) ? '0 : (dy[CW-1] ? '1 : BOARD_BITS'(1));

    // Walk position advances modulo the board width; the geometry check keeps
    // every visited square on the board.
    nx         = cx_q + sx_q;
    ny         = cy_q + sy_q;
    next_is_to = (nx == tx_q) && (ny == ty_q);

    rd_owner = (rd_data > 4'd6);
    dest_own = (rd_data != 4'd0) && (rd_owner == player_q);
    dest_opp = (rd_data != 4'd0) && (rd_owner != player_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rd_x            <= '0;
      rd_y            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      valid           <= 1'b0;
      piece_q         <= '0;
      player_q        <= 1'b0;
      fx_q            <= '0;
      fy_q            <= '0;
      tx_q            <= '0;
      ty_q            <= '0;
      cx_q            <= '0;
      cy_q            <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      walk_q          <= 1'b0;
      pawn_straight_q <= 1'b0;
      pawn_diag_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            piece_q  <= piece;
            player_q <= current_player;
            fx_q     <= from_x;
            fy_q     <= from_y;
            tx_q     <= to_x;
            ty_q     <= to_y;
            busy     <= 1'b1;
            valid    <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (!piece_ok || same_sq || !geom_ok) begin
            done  <= 1'b1;
            valid <= 1'b0;
            state <= DONE;
          end else begin
            // Address is registered here so it is stable for all of DADDR.
            rd_x            <= tx_q;
            rd_y            <= ty_q;
            cx_q            <= fx_q;
            cy_q            <= fy_q;
            sx_q            <= sx_c;
            sy_q            <= sy_c;
            walk_q          <= walk_needed;
            pawn_straight_q <= (kind == 4'd1) && (dy == '0);
            pawn_diag_q     <= (kind == 4'd1) && (ady == CW'(1));
            state           <= DADDR;
          end
        end
        DADDR: state <= DDATA;
        DDATA: begin
          if (dest_own || (pawn_straight_q && rd_data != 4'd0) ||
              (pawn_diag_q && !dest_opp)) begin
            done  <= 1'b1;
            valid <= 1'b0;
            state <= DONE;
          end else if (!walk_q || next_is_to) begin
            done  <= 1'b1;
            valid <= 1'b1;
            state <= DONE;
          end else begin
            cx_q  <= nx;
            cy_q  <= ny;
            rd_x  <= nx;
            rd_y  <= ny;
            state <= PADDR;
          end
        end
        PADDR: state <= PDATA;
        PDATA: begin
          if (rd_data != 4'd0) begin
            done  <= 1'b1;
            valid <= 1'b0;
            state <= DONE;
          end else if (next_is_to) begin
            done  <= 1'b1;
            valid <= 1'b1;
            state <= DONE;
          end else begin
            cx_q  <= nx;
            cy_q  <= ny;
            rd_x  <= nx;
            rd_y  <= ny;
            state <= PADDR;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_validator.sv
// Bench for move_validator: table of directed moves against a standard opening
// board, plus sequences for start-in-DONE and reset during a path walk.
module tb_move_validator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] piece;
  logic       current_player;
  logic [2:0] from_x, from_y, to_x, to_y;
  logic [2:0] rd_x, rd_y;
  logic [3:0] rd_data;
  logic       busy, done, valid;
  logic [2:0] state_dbg;

  move_validator #(.BOARD_BITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .piece(piece),
    .current_player(current_player),
    .from_x(from_x), .from_y(from_y), .to_x(to_x), .to_y(to_y),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .busy(busy), .done(done), .valid(valid), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Board memory with one-cycle synchronous read
  logic [3:0] board [0:7][0:7];
  always @(posedge clk) rd_data <= board[rd_x][rd_y];

`ifdef MOVE_VALIDATOR_PAWN_DOUBLE_EN
  localparam int   DBL_LAT   = 6;
  localparam logic DBL_VALID = 1'b1;
`else
  localparam int   DBL_LAT   = 2;
  localparam logic DBL_VALID = 1'b0;
`endif

  typedef struct {
    logic [3:0] piece;
    logic       player;
    logic [2:0] fx, fy, tx, ty;
    int         board_kind;   // 0 opening, 1 opening plus one placed code, 2 rank 0 cleared except (0,0)
    logic [2:0] mx, my;
    logic [3:0] mv;
    int         exp_lat;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] pc, input logic pl,
                              input logic [2:0] fx, input logic [2:0] fy,
                              input logic [2:0] tx, input logic [2:0] ty,
                              input int bk, input logic [2:0] mx,
                              input logic [2:0] my, input logic [3:0] mv,
                              input int lat, input logic v);
    vec_t r;
    r.piece = pc; r.player = pl; r.fx = fx; r.fy = fy; r.tx = tx; r.ty = ty;
    r.board_kind = bk; r.mx = mx; r.my = my; r.mv = mv;
    r.exp_lat = lat; r.exp_valid = v;
    return r;
  endfunction

  task automatic set_board(input int kind, input logic [2:0] mx,
                           input logic [2:0] my, input logic [3:0] mv);
    logic [3:0] back [0:7];
    back = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd4, 4'd3, 4'd2};
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        board[x][y] = 4'd0;
    for (int y = 0; y < 8; y++) begin
      board[0][y] = back[y];
      board[1][y] = 4'd1;
      board[6][y] = 4'd7;
      board[7][y] = back[y] + 4'd6;
    end
    if (kind == 1) board[mx][my] = mv;
    if (kind == 2)
      for (int y = 1; y < 8; y++) board[0][y] = 4'd0;
  endtask

  task automatic drive_move(input vec_t v);
    piece          = v.piece;
    current_player = v.player;
    from_x = v.fx; from_y = v.fy; to_x = v.tx; to_y = v.ty;
    start  = 1'b1;
  endtask

  // Called just after a negedge with the DUT in IDLE; returns just after the
  // negedge of the cycle following DONE (IDLE again).
  task automatic run_move(input vec_t v, input int idx);
    int lat;
    set_board(v.board_kind, v.mx, v.my, v.mv);
    drive_move(v);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check($sformatf("v%0d_busy", idx), int'(busy), 1);
        // Garbage inputs and a stray start while busy must be ignored.
        piece  = 4'($urandom_range(0, 15));
        current_player = 1'($urandom_range(0, 1));
        from_x = 3'($urandom_range(0, 7)); from_y = 3'($urandom_range(0, 7));
        to_x   = 3'($urandom_range(0, 7)); to_y   = 3'($urandom_range(0, 7));
        start  = 1'b1;
      end else if (k == 2) begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_valid", idx), int'(valid), int'(v.exp_valid));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), int'(done), 0);
    check($sformatf("v%0d_busy_clear", idx), int'(busy), 0);
    check($sformatf("v%0d_valid_held", idx), int'(valid), int'(v.exp_valid));
  endtask

  initial begin
    vec_t v;
    int   cnt;

    // Directed vectors: piece, player, from, to, board, placed square, latency, verdict
    vecs.push_back(mk(4'd3,  1'b0, 0, 1, 2, 2, 0, 0, 0, 0,  4,  1'b1)); // knight jump
    vecs.push_back(mk(4'd2,  1'b0, 0, 0, 3, 0, 0, 0, 0, 0,  6,  1'b0)); // rook blocked at (1,0)
    vecs.push_back(mk(4'd1,  1'b0, 1, 4, 3, 4, 0, 0, 0, 0,  DBL_LAT, DBL_VALID)); // pawn double
    vecs.push_back(mk(4'd1,  1'b1, 1, 0, 2, 0, 0, 0, 0, 0,  2,  1'b0)); // not own piece
    vecs.push_back(mk(4'd1,  1'b0, 1, 3, 2, 4, 0, 0, 0, 0,  4,  1'b0)); // diagonal onto empty
    vecs.push_back(mk(4'd1,  1'b0, 1, 3, 2, 4, 1, 2, 4, 7,  4,  1'b1)); // diagonal capture
    vecs.push_back(mk(4'd2,  1'b0, 0, 0, 0, 7, 2, 0, 0, 0,  16, 1'b1)); // longest rook walk
    vecs.push_back(mk(4'd3,  1'b0, 0, 1, 0, 1, 0, 0, 0, 0,  2,  1'b0)); // from == to
    vecs.push_back(mk(4'd0,  1'b0, 3, 3, 4, 4, 0, 0, 0, 0,  2,  1'b0)); // empty piece code
    vecs.push_back(mk(4'd13, 1'b1, 3, 3, 4, 4, 0, 0, 0, 0,  2,  1'b0)); // out-of-range code
    vecs.push_back(mk(4'd4,  1'b0, 0, 2, 2, 4, 0, 0, 0, 0,  6,  1'b0)); // bishop blocked
    vecs.push_back(mk(4'd1,  1'b0, 1, 0, 2, 0, 0, 0, 0, 0,  4,  1'b1)); // pawn single step
    vecs.push_back(mk(4'd3,  1'b0, 0, 1, 1, 3, 0, 0, 0, 0,  4,  1'b0)); // knight onto own piece
    vecs.push_back(mk(4'd9,  1'b1, 7, 1, 5, 2, 0, 0, 0, 0,  4,  1'b1)); // player 1 knight
    vecs.push_back(mk(4'd6,  1'b0, 0, 4, 2, 4, 0, 0, 0, 0,  2,  1'b0)); // king two squares
    vecs.push_back(mk(4'd7,  1'b1, 6, 5, 4, 5, 0, 0, 0, 0,  DBL_LAT, DBL_VALID)); // player 1 double
    vecs.push_back(mk(4'd1,  1'b0, 1, 2, 2, 2, 1, 2, 2, 7,  4,  1'b0)); // pawn straight blocked
    vecs.push_back(mk(4'd2,  1'b0, 0, 0, 0, 1, 2, 0, 0, 0,  4,  1'b1)); // adjacent rook move
    vecs.push_back(mk(4'd2,  1'b0, 0, 0, 1, 1, 0, 0, 0, 0,  2,  1'b0)); // rook diagonal
    vecs.push_back(mk(4'd1,  1'b0, 1, 0, 0, 0, 0, 0, 0, 0,  2,  1'b0)); // pawn backward
    vecs.push_back(mk(4'd5,  1'b0, 0, 3, 3, 6, 1, 1, 4, 0,  4,  1'b0)); // queen diag, dest (3,6) empty, path (1,4) cleared... see below

    // The last entry places 0 at (1,4): path (1,4),(2,5) empty, dest (3,6) empty
    // gives a legal walk of two squares -> latency 8.
    vecs[vecs.size()-1].exp_lat   = 8;
    vecs[vecs.size()-1].exp_valid = 1'b1;

    reset = 1'b1; start = 1'b0; piece = '0; current_player = 1'b0;
    from_x = '0; from_y = '0; to_x = '0; to_y = '0;
    set_board(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  int'(busy),  0);
    check("reset_done",  int'(done),  0);
    check("reset_valid", int'(valid), 0);
    check("reset_rd_x",  int'(rd_x),  0);
    check("reset_rd_y",  int'(rd_y),  0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_move(vecs[i], i);

    // Start asserted during DONE must be ignored.
    v = mk(4'd3, 1'b0, 0, 1, 2, 2, 0, 0, 0, 0, 4, 1'b1);
    set_board(0, 0, 0, 0);
    drive_move(v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 2; k <= 24 && !done; k++) @(negedge clk);
    check("done_seen_before_ignore", int'(done), 1);
    piece = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    check("start_in_done_ignored", cnt, 0);

    // Reset in the middle of the longest walk.
    v = mk(4'd2, 1'b0, 0, 0, 0, 7, 2, 0, 0, 0, 16, 1'b1);
    set_board(2, 0, 0, 0);
    drive_move(v);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("walk_busy_before_reset", int'(busy), 1);
    check("walk_rd_y_before_reset", int'(rd_y), 3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy",  int'(busy),      0);
    check("midreset_done",  int'(done),      0);
    check("midreset_valid", int'(valid),     0);
    check("midreset_rd_x",  int'(rd_x),      0);
    check("midreset_rd_y",  int'(rd_y),      0);
    check("midreset_state", int'(state_dbg), 0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("midreset_no_done", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_validator.md
# move_validator

Chess move-legality checker used by the game controller while it grants board-memory access to the validator (memory_manage = 01). On a start pulse it captures the selected piece, source square, destination square and side to move. It then reads the destination square and any intermediate squares from the board memory. It reports a single `done` pulse with a held `valid` verdict, and replaces the controller's mocked counter-based validator.

## Interface
Parameters:
- BOARD_BITS, 3, coordinate width; board is 2^BOARD_BITS squares per side (8x8).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- piece  in  4  code of moving piece: 0 empty; 1-6 player 0 pawn, rook, knight, bishop, queen, king; 7-12 player 1 same order
- current_player  in  1  side to move (0/1)
- from_x, from_y  in  3  source square; x = rank (player 0 advances +x), y = file; (0,0) bottom-left
- to_x, to_y  in  3  destination square
- rd_x, rd_y  out  3  board read address, registered
- rd_data  in  4  board contents at rd_x/rd_y, valid one cycle after the address changes
- busy  out  1  high from the cycle after start acceptance until DONE inclusive
- done  out  1  one-cycle completion pulse
- valid  out  1  verdict; updated in DONE, held until next accepted start

## Operation
- Inputs are captured at start and internally derive dx = to_x - from_x and dy = to_y - from_y as signed 4-bit values. Own = piece owned by current_player; opp = nonzero square owned by the other side.
- States: IDLE, CHECK, DADDR, DDATA, PADDR, PDATA, DONE.
- IDLE: on start, capture inputs and go to CHECK.
- CHECK, rejecting without reading memory if any of the following holds:
  - piece == 0, piece > 12, or piece not own.
  - from == to.
  - Geometry illegal for the piece type:
    - rook: dx == 0 xor dy == 0.
    - bishop: |dx| == |dy|.
    - queen: rook or bishop rule.
    - knight: {|dx|,|dy|} = {1,2}.
    - king: |dx| ≤ 1 and |dy| ≤ 1.
    - pawn: forward one (dy = 0), forward diagonal (|dy| = 1), or forward two (dy = 0, source on start rank x = 1 for player 0, x = 6 for player 1). Forward means +1 for player 0 and -1 for player 1.
- If CHECK passes, go to DADDR.
- DADDR sets the read address to to; DDATA samples rd_data.
  - Destination own → reject.
  - Pawn straight move with destination nonzero → reject.
  - Pawn diagonal move with destination not opp → reject.
- Path walk (rook, bishop, queen, pawn double step):
  - Step = (sign dx, sign dy); walk squares from+step up to but excluding to.
  - Each square costs PADDR + PDATA; any nonzero square → reject.
  - Adjacent moves have no path squares: go straight to DONE with valid = 1.
- Knight, king and pawn single/diagonal moves skip the path walk.
- DONE: done = 1, valid = verdict, then IDLE.
- Check, pins and castling are not evaluated.

## Timing
- Reset values: rd_x = rd_y = 0, busy = 0, done = 0, valid = 0; state IDLE.
- start at cycle T (IDLE):
  - Rejection in CHECK: done at T+2.
  - Legal or illegal verdict at the destination: done at T+4.
  - Sliding or double-step move with n intermediate squares: done at T+4+2n, at most T+16 (n = 6). An early reject on a blocked square shortens this.
- start while not IDLE is ignored. Input changes after acceptance are ignored.
- start in the DONE cycle is ignored. Back-to-back requests require start one cycle after done.
- reset mid-walk returns to IDLE the next cycle with all outputs at reset values; no done is issued.
- Coordinate arithmetic is done in 4-bit signed form. The walk never leaves the board because the geometry check precedes it.

## Configuration
- MOVE_VALIDATOR_PAWN_DOUBLE_EN
  - Defined: the pawn two-square first move is legal, including an emptiness check of the intermediate square.
  - Undefined: a pawn with |dx| = 2 is rejected in CHECK (done at T+2), and pawns never enter the path walk.

## Test plan
Use a standard opening board: player 0 back rank x=0 holds 2,3,4,5,6,4,3,2, pawns are 1 at x=1; player 1 mirror at x=7/x=6 with codes +6.

- Player 0 knight (0,1)→(2,2), current_player = 0 → done at T+4, valid = 1.
- Player 0 rook (0,0)→(3,0) → blocked at (1,0); done at T+6, valid = 0.
- Pawn (1,4)→(3,4) with the macro defined → done at T+6, valid = 1. Same move without the macro → done at T+2, valid = 0.
- current_player = 1 selecting piece 1 at (1,0) → done at T+2, valid = 0.
- Pawn diagonal (1,3)→(2,4) onto an empty square → valid = 0. Same move with code 7 placed at (2,4) → valid = 1.
- Rook (0,0)→(0,7) on a cleared rank:
  - No blockers → done at T+16, valid = 1.
  - reset asserted at T+8 → busy/done/valid = 0 at T+9; no done pulse follows.
